// File: rtl/xilly_param_fifo.sv
// Parametrised single-clock FIFO with optional first-word-fall-through output,
// almost-full/almost-empty thresholds, occupancy count and error pulses.
module xilly_param_fifo #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 512,
   parameter int FWFT      = 0,
   parameter int AF_THRESH = DEPTH - 4,
   parameter int AE_THRESH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           din,
   input  logic                       wr_en,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     data_count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
   localparam logic [AW:0]   AF_C    = AF_THRESH[AW:0];
   localparam logic [AW:0]   AE_C    = AE_THRESH[AW:0];
   localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             overflow_reg;
   logic             underflow_reg;
   logic             wr_ok;
   logic             rd_ok;

   // All flags come from the registered count; no path from wr_en/rd_en.
   assign full         = (count_reg == DEPTH_C);
   assign empty        = (count_reg == '0);
   assign almost_full  = (count_reg >= AF_C);
   assign almost_empty = (count_reg <= AE_C);
   assign data_count   = count_reg;
   assign overflow     = overflow_reg;
   assign underflow    = underflow_reg;

   assign wr_ok = wr_en && !full;
   assign rd_ok = rd_en && !empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (wr_ok)
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (rd_ok)
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         case ({wr_ok, rd_ok})
            2'b10:   count_reg <= count_reg + CNT_ONE;
            2'b01:   count_reg <= count_reg - CNT_ONE;
            default: count_reg <= count_reg;
         endcase
         overflow_reg  <= wr_en && full;
         underflow_reg <= rd_en && empty;
      end
   end

   // Storage is deliberately left out of reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_ptr_reg] <= din;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is presented directly; forced to zero while empty.
         assign dout = empty ? '0 : mem[rd_ptr_reg];
      end else begin : g_std
         logic [WIDTH-1:0] dout_reg;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               dout_reg <= '0;
            else if (rd_ok)
               dout_reg <= mem[rd_ptr_reg];
         end
         assign dout = dout_reg;
      end
   endgenerate

endmodule

// File: tb/tb_xilly_param_fifo.sv
// Directed self-checking bench: standard-mode and FWFT instances, DEPTH=8.
module tb_xilly_param_fifo;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic [31:0] s_din = '0;
   logic        s_wr_en = 1'b0, s_rd_en = 1'b0;
   logic [31:0] s_dout;
   logic        s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
   logic [3:0]  s_count;

   logic [31:0] f_din = '0;
   logic        f_wr_en = 1'b0, f_rd_en = 1'b0;
   logic [31:0] f_dout;
   logic        f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
   logic [3:0]  f_count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   xilly_param_fifo #(.WIDTH(32), .DEPTH(8), .FWFT(0), .AF_THRESH(4), .AE_THRESH(4)) u_std (
      .clk(clk), .rst(rst), .din(s_din), .wr_en(s_wr_en), .rd_en(s_rd_en),
      .dout(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
      .almost_empty(s_ae), .data_count(s_count), .overflow(s_ovf), .underflow(s_unf)
   );

   xilly_param_fifo #(.WIDTH(32), .DEPTH(8), .FWFT(1), .AF_THRESH(4), .AE_THRESH(4)) u_fwft (
      .clk(clk), .rst(rst), .din(f_din), .wr_en(f_wr_en), .rd_en(f_rd_en),
      .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
      .almost_empty(f_ae), .data_count(f_count), .overflow(f_ovf), .underflow(f_unf)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      #22;
      chk("rst_count", {28'd0, s_count}, 32'd0);
      chk("rst_empty", {31'd0, s_empty}, 32'd1);
      chk("rst_full", {31'd0, s_full}, 32'd0);
      chk("rst_af", {31'd0, s_af}, 32'd0);
      chk("rst_ae", {31'd0, s_ae}, 32'd1);
      chk("rst_dout", s_dout, 32'd0);
      chk("rst_ovf", {31'd0, s_ovf}, 32'd0);
      chk("rst_unf", {31'd0, s_unf}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;

      // Fill 1..8
      for (int i = 1; i <= 8; i++) begin
         s_din = i; s_wr_en = 1'b1;
         tick();
         chk($sformatf("fill%0d_count", i), {28'd0, s_count}, i);
         chk($sformatf("fill%0d_empty", i), {31'd0, s_empty}, 32'd0);
         chk($sformatf("fill%0d_af", i), {31'd0, s_af}, (i >= 4) ? 32'd1 : 32'd0);
         chk($sformatf("fill%0d_full", i), {31'd0, s_full}, (i == 8) ? 32'd1 : 32'd0);
      end

      // Overflow on full
      s_din = 32'hDEAD;
      tick();
      chk("ovf_pulse", {31'd0, s_ovf}, 32'd1);
      chk("ovf_count", {28'd0, s_count}, 32'd8);
      s_wr_en = 1'b0;
      tick();
      chk("ovf_clear", {31'd0, s_ovf}, 32'd0);
      chk("ovf_count2", {28'd0, s_count}, 32'd8);

      // Drain in order
      for (int i = 1; i <= 8; i++) begin
         s_rd_en = 1'b1;
         tick();
         chk($sformatf("drain%0d_dout", i), s_dout, i);
         chk($sformatf("drain%0d_count", i), {28'd0, s_count}, 8 - i);
         chk($sformatf("drain%0d_ae", i), {31'd0, s_ae}, (8 - i <= 4) ? 32'd1 : 32'd0);
      end
      s_rd_en = 1'b0;
      chk("drain_empty", {31'd0, s_empty}, 32'd1);
      chk("drain_unf", {31'd0, s_unf}, 32'd0);

      // Simultaneous read/write on empty
      s_rd_en = 1'b1; s_wr_en = 1'b1; s_din = 32'h55;
      tick();
      chk("sim_unf", {31'd0, s_unf}, 32'd1);
      chk("sim_ovf", {31'd0, s_ovf}, 32'd0);
      chk("sim_count", {28'd0, s_count}, 32'd1);
      s_wr_en = 1'b0;
      tick();
      s_rd_en = 1'b0;
      chk("sim_dout", s_dout, 32'h55);
      chk("sim_count2", {28'd0, s_count}, 32'd0);
      chk("sim_unf_clear", {31'd0, s_unf}, 32'd0);
      tick();
      chk("hold_dout", s_dout, 32'h55);

      // Wrap-around streaming at occupancy 3
      for (int k = 0; k < 3; k++) begin
         s_din = 32'd100 + k; s_wr_en = 1'b1;
         tick();
      end
      for (int k = 0; k < 40; k++) begin
         s_din = 32'd103 + k; s_wr_en = 1'b1; s_rd_en = 1'b1;
         tick();
         chk($sformatf("stream%0d_dout", k), s_dout, 32'd100 + k);
         chk($sformatf("stream%0d_count", k), {28'd0, s_count}, 32'd3);
         chk($sformatf("stream%0d_err", k), {30'd0, s_ovf, s_unf}, 32'd0);
      end
      s_rd_en = 1'b0;
      // Two more writes bring occupancy to 5
      s_din = 32'd143; tick();
      s_din = 32'd144; tick();
      s_wr_en = 1'b0;
      chk("pre_rst_count", {28'd0, s_count}, 32'd5);

      // Async reset between edges
      #3 rst = 1'b0;
      #1;
      chk("arst_count", {28'd0, s_count}, 32'd0);
      chk("arst_empty", {31'd0, s_empty}, 32'd1);
      chk("arst_full", {31'd0, s_full}, 32'd0);
      chk("arst_dout", s_dout, 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      s_din = 32'h77; s_wr_en = 1'b1;
      tick();
      s_wr_en = 1'b0; s_rd_en = 1'b1;
      tick();
      s_rd_en = 1'b0;
      chk("post_rst_dout", s_dout, 32'h77);
      chk("post_rst_empty", {31'd0, s_empty}, 32'd1);

      // FWFT instance
      f_din = 32'hA; f_wr_en = 1'b1;
      tick();
      chk("fwft_dout_a", f_dout, 32'hA);
      chk("fwft_empty_a", {31'd0, f_empty}, 32'd0);
      f_din = 32'hB;
      tick();
      f_wr_en = 1'b0;
      chk("fwft_hold_a", f_dout, 32'hA);
      chk("fwft_count2", {28'd0, f_count}, 32'd2);
      f_rd_en = 1'b1;
      tick();
      chk("fwft_dout_b", f_dout, 32'hB);
      chk("fwft_count1", {28'd0, f_count}, 32'd1);
      tick();
      f_rd_en = 1'b0;
      chk("fwft_empty", {31'd0, f_empty}, 32'd1);
      chk("fwft_count0", {28'd0, f_count}, 32'd0);
      chk("fwft_unf", {31'd0, f_unf}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
